// File: rtl/rv_run_ctrl.sv
// Load/run/dump controller for a small RISC-V core: streams an image into core memory,
// pulses core reset, runs until SYSTEM (or watchdog with RV_RUN_CTRL_TIMEOUT_EN), dumps registers.
module rv_run_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned AW         = 16,
  parameter int unsigned TIMEOUT    = 10000,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     cpu_rst,
  output logic                     cpu_run,
  input  logic [XLEN-1:0]          inst,
  output logic [$clog2(NREGS)-1:0] reg_idx,
  input  logic [XLEN-1:0]          reg_rdata,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [$clog2(NREGS)-1:0] dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     done,
  output logic                     timed_out,
  output logic [31:0]              cycles
);

  localparam int unsigned IW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(RST_CYCLES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CRST = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DUMP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

`ifndef RV_RUN_CTRL_TIMEOUT_EN
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          to_q, to_d;
  logic          sys_c;
  logic          unused_inst;

  assign sys_c       = (inst[6:0] == 7'b1110011);
  assign unused_inst = ^inst[XLEN-1:7];

  // Next-state and datapath updates; mem_we is the only purely combinational strobe.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    rcnt_d   = rcnt_q;
    cycles_d = cycles_q;
    to_d     = to_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          // The top address ends the load so later bytes can never wrap onto address 0.
          if (ld_last || (ptr_q == {AW{1'b1}})) begin
            state_d = S_CRST;
            rcnt_d  = '0;
          end
        end
      end
      S_CRST: begin
        cycles_d = '0;
        if (rcnt_q == CW'(RST_CYCLES - 1)) state_d = S_RUN;
        else rcnt_d = rcnt_q + CW'(1);
      end
      S_RUN: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (sys_c) begin
          state_d = S_DUMP;
          idx_d   = '0;
          to_d    = 1'b0;
        end
`ifdef RV_RUN_CTRL_TIMEOUT_EN
        else if (cycles_q == 32'(TIMEOUT - 1)) begin
          state_d = S_DUMP;
          idx_d   = '0;
          to_d    = 1'b1;
        end
`endif
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (idx_q == IW'(NREGS - 1)) state_d = S_DONE;
          else idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          to_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      rcnt_q   <= '0;
      cycles_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      rcnt_q   <= rcnt_d;
      cycles_q <= cycles_d;
      to_q     <= to_d;
    end
  end

  // Status and control are straight decodes of the state register.
  assign ld_ready   = (state_q == S_LOAD);
  assign mem_addr   = ptr_q;
  assign mem_wdata  = ld_data;
  assign cpu_rst    = (state_q == S_IDLE) || (state_q == S_CRST);
  assign cpu_run    = (state_q == S_RUN);
  assign reg_idx    = idx_q;
  assign dump_idx   = idx_q;
  assign dump_valid = (state_q == S_DUMP);
  assign dump_data  = reg_rdata;
  assign done       = (state_q == S_DONE);
  assign cycles     = cycles_q;
  assign timed_out  = to_q;

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Directed bench for rv_run_ctrl (AW=4, TIMEOUT=40) with immediate-assertion checks.
module tb_rv_run_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned TOUT = 40;

  logic clk = 1'b0;
  logic rst_n, start, ld_valid, ld_last, ld_ready, mem_we;
  logic [7:0] ld_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic cpu_rst, cpu_run, dump_valid, dump_ready, done, timed_out;
  logic [XLEN-1:0] inst, reg_rdata, dump_data;
  logic [4:0] reg_idx, dump_idx;
  logic [31:0] cycles;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign reg_rdata = 32'hA500_0000 | 32'(reg_idx);

  rv_run_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .TIMEOUT(TOUT), .RST_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .cpu_run(cpu_run), .inst(inst),
    .reg_idx(reg_idx), .reg_rdata(reg_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .done(done), .timed_out(timed_out), .cycles(cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] img [8];
    int e;
    int runs;
    logic [3:0] rpat;
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b1; ld_data = 8'h5A; ld_last = 1'b0;
    inst = 32'h0000_0013; dump_ready = 1'b0;
    #12;
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_cpu_run", 64'(cpu_run), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_dump_idx", 64'(dump_idx), 64'd0);
    chk("rst_reg_idx", 64'(reg_idx), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_timed_out", 64'(timed_out), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ld_ready", 64'(ld_ready), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ld_ready", 64'(ld_ready), 64'd1);
    chk("load_cpu_run", 64'(cpu_run), 64'd0);

    // 8-byte image ending with ld_last
    for (int k = 0; k < 8; k++) begin
      ld_valid = 1'b1; ld_data = img[k]; ld_last = (k == 7);
      #1;
      chk("img_we", 64'(mem_we), 64'd1);
      chk("img_addr", 64'(mem_addr), 64'(k));
      chk("img_wdata", 64'(mem_wdata), 64'(img[k]));
      tick();
    end
    ld_last = 1'b0; ld_data = 8'hEE;
    #1;
    chk("crst_ld_ready", 64'(ld_ready), 64'd0);
    chk("crst_no_we", 64'(mem_we), 64'd0);
    chk("crst_rst1", 64'(cpu_rst), 64'd1);
    tick();
    chk("crst_rst2", 64'(cpu_rst), 64'd1);
    chk("crst_cycles0", 64'(cycles), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b0;
    chk("run_rst_low", 64'(cpu_rst), 64'd0);
    chk("run_cpu_run", 64'(cpu_run), 64'd1);
    chk("run_cycles0", 64'(cycles), 64'd0);

    // SYSTEM on the 5th RUN cycle
    for (int k = 0; k < 4; k++) tick();
    chk("run_cycles4", 64'(cycles), 64'd4);
    chk("run_still", 64'(cpu_run), 64'd1);
    inst = 32'h0000_0073;
    tick();
    inst = 32'h0000_0013;
    chk("sys_cycles", 64'(cycles), 64'd5);
    chk("sys_timed_out", 64'(timed_out), 64'd0);
    chk("sys_cpu_run", 64'(cpu_run), 64'd0);
    chk("sys_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("sys_dump_valid", 64'(dump_valid), 64'd1);

    // start ignored in DUMP while stalled
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dump_start_ign", 64'(dump_valid), 64'd1);

    // ready pattern 1,0,0,1 then continuous
    rpat = 4'b1001;
    e = 0;
    for (int c = 0; c < 40 && dump_valid; c++) begin
      dump_ready = (c < 4) ? rpat[3 - c] : 1'b1;
      #1;
      chk("dump_idx", 64'(dump_idx), 64'(e));
      chk("dump_data", 64'(dump_data), 64'(32'hA500_0000 + 32'(e)));
      if (dump_ready) e++;
      tick();
    end
    dump_ready = 1'b0;
    chk("dump_count", 64'(e), 64'd32);
    chk("done_set", 64'(done), 64'd1);
    chk("done_no_valid", 64'(dump_valid), 64'd0);
    chk("done_cycles", 64'(cycles), 64'd5);
    chk("done_to", 64'(timed_out), 64'd0);
    tick();
    chk("done_hold", 64'(done), 64'd1);

    // restart; 20 bytes without ld_last into a 16-byte space
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_ready", 64'(ld_ready), 64'd1);
    runs = 0;
    for (int k = 0; k < 20; k++) begin
      ld_valid = 1'b1; ld_data = 8'(8'h80 + k); ld_last = 1'b0;
      #1;
      if (k < 16) begin
        chk("ovf_we", 64'(mem_we), 64'd1);
        chk("ovf_addr", 64'(mem_addr), 64'(k));
      end else begin
        chk("ovf_ready_low", 64'(ld_ready), 64'd0);
        chk("ovf_no_we", 64'(mem_we), 64'd0);
      end
      if (cpu_run) runs++;
      tick();
    end
    ld_valid = 1'b0;
    chk("ovf_runs", 64'(runs), 64'd2);

`ifdef RV_RUN_CTRL_TIMEOUT_EN
    for (int j = 0; j < 100 && !dump_valid; j++) begin
      if (cpu_run) runs++;
      tick();
    end
    chk("to_dump", 64'(dump_valid), 64'd1);
    chk("to_runs", 64'(runs), 64'(TOUT));
    chk("to_cycles", 64'(cycles), 64'(TOUT));
    chk("to_flag", 64'(timed_out), 64'd1);
`else
    for (int j = 0; j < 100; j++) begin
      if (cpu_run) runs++;
      tick();
    end
    chk("nto_run", 64'(cpu_run), 64'd1);
    chk("nto_flag", 64'(timed_out), 64'd0);
    runs++;
    inst = 32'h0000_0073;
    tick();
    inst = 32'h0000_0013;
    chk("nto_dump", 64'(dump_valid), 64'd1);
    chk("nto_cycles", 64'(cycles), 64'(runs));
`endif

    // abort mid-dump at index 7
    dump_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    dump_ready = 1'b0;
    chk("abort_idx7", 64'(dump_idx), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(dump_valid), 64'd0);
    chk("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("abort_idx", 64'(dump_idx), 64'd0);
    chk("abort_to", 64'(timed_out), 64'd0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hAB; ld_last = 1'b1;
    #1;
    chk("fresh_we", 64'(mem_we), 64'd1);
    chk("fresh_addr", 64'(mem_addr), 64'd0);
    chk("fresh_data", 64'(mem_wdata), 64'hAB);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("fresh_crst", 64'(cpu_rst), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rv_run_ctrl.md
RV_RUN_CTRL -- requirements
Module: rv_run_ctrl

Interface
REQ-001 SHALL have parameters: XLEN, default 32, core data width; NREGS, default 32, registers dumped; AW, default 16, load address width; TIMEOUT, default 10000, run-cycle limit; RST_CYCLES, default 2, core reset hold.
REQ-002 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin load/run (sampled in IDLE and DONE).
- ld_valid, in, 1; ld_data, in, 8; ld_last, in, 1; ld_ready, out, 1: image byte stream.
- mem_we, out, 1; mem_addr, out, AW; mem_wdata, out, 8: byte write port to core memory.
- cpu_rst, out, 1: active-high core reset.
- cpu_run, out, 1: core clock enable.
- inst, in, XLEN: core's current instruction.
- reg_idx, out, $clog2(NREGS): register-file read index.
- reg_rdata, in, XLEN: combinational register-file read data.
- dump_valid, out, 1; dump_ready, in, 1; dump_idx, out, $clog2(NREGS); dump_data, out, XLEN: register dump stream.
- done, out, 1; timed_out, out, 1; cycles, out, 32: status.

Function
REQ-003 SHALL implement states IDLE, LOAD, CRST, RUN, DUMP, DONE.
REQ-004 IDLE: cpu_rst=1, cpu_run=0, ld_ready=0; start=1 -> LOAD, load pointer=0.
REQ-005 LOAD: ld_ready=1; mem_we = ld_valid & ld_ready combinationally; mem_addr = pointer; mem_wdata = ld_data; pointer increments on every accepted byte.
REQ-006 LOAD exit: accepted byte with ld_last=1, or accepted byte at pointer 2^AW-1 (no wrap, later bytes never written) -> CRST.
REQ-007 CRST: cpu_rst=1 for exactly RST_CYCLES cycles, cycles cleared to 0, then -> RUN.
REQ-008 RUN: cpu_rst=0, cpu_run=1; cycles increments by 1 every RUN cycle, saturating at 2^32-1.
REQ-009 RUN: inst[6:0]==7'b1110011 (SYSTEM) -> DUMP next cycle, timed_out=0; cpu_run=0 from that cycle onward.
REQ-010 RUN: cycles==TIMEOUT-1 without SYSTEM -> DUMP, timed_out=1; simultaneous SYSTEM and timeout resolve as SYSTEM (timed_out=0).
REQ-011 DUMP: index i starts at 0; reg_idx=i, dump_idx=i, dump_data=reg_rdata, dump_valid=1; cpu_run=0, cpu_rst=0 (register contents preserved).
REQ-012 DUMP handshake: transfer when dump_valid & dump_ready; i increments; dump_idx/dump_data stable while dump_ready=0; transfer at i==NREGS-1 -> DONE.
REQ-013 DONE: done=1, cycles and timed_out held; start=1 -> LOAD (pointer=0, done=0, timed_out=0).
REQ-014 start SHALL be ignored in LOAD, CRST, RUN and DUMP.
REQ-015 ld_ready SHALL be 0 outside LOAD; mem_we SHALL never be 1 outside LOAD.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE from any state, including mid-LOAD and mid-DUMP.
REQ-017 Reset values: cpu_rst=1, cpu_run=0, ld_ready=0, mem_we=0, mem_addr=0, dump_valid=0, dump_idx=0, reg_idx=0, done=0, timed_out=0, cycles=0.

Configuration
REQ-018 Macro RV_RUN_CTRL_TIMEOUT_EN SHALL compile in the timeout watchdog of REQ-010.
REQ-019 Without RV_RUN_CTRL_TIMEOUT_EN, RUN SHALL exit only on SYSTEM, timed_out SHALL be constant 0, and TIMEOUT SHALL be unused.

Verification
REQ-020 Stream 8 bytes 0x13,0x00,0x00,0x00,0x73,0x00,0x00,0x00 with ld_last on the 8th byte -> mem_we pulses at addresses 0..7 with matching data, then cpu_rst high for exactly 2 cycles.
REQ-021 inst=0x00000073 on the 5th RUN cycle -> cycles=5, timed_out=0, cpu_run=0 next cycle; 32 dump transfers idx 0..31 with data=reg_rdata; then done=1.
REQ-022 inst held at 0x00000013 with TIMEOUT=10000 (macro defined) -> DUMP entered after 10000 RUN cycles, timed_out=1.
REQ-023 dump_ready toggled 1,0,0,1 -> dump_idx/dump_data held during stalls, no skipped or repeated index.
REQ-024 rst_n low during DUMP at idx 7 -> IDLE immediately, dump_valid=0, cpu_rst=1; a fresh start reloads from address 0.
REQ-025 AW=4 with 20 bytes streamed and no ld_last -> 16 writes at 0..15, then CRST; ld_ready=0 afterward.
